// File: rtl/id_decode_stage_if.sv
// Handshake bundle for the ID stage: instruction in, decoded entry out.
// The master side drives the instruction and downstream ready; the slave side is the stage.
interface id_decode_stage_if #(
    parameter int IW = 19,
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] ir_in;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   ctrl_out;
    logic [3:0]    func_out;
    logic [DW-1:0] imm_out;
    logic          illegal_out;

    modport master (
        output in_valid, ir_in, out_ready,
        input  in_ready, out_valid, ctrl_out, func_out, imm_out, illegal_out
    );

    modport slave (
        input  in_valid, ir_in, out_ready,
        output in_ready, out_valid, ctrl_out, func_out, imm_out, illegal_out
    );
endinterface

// File: rtl/id_decode_stage.sv
// Registered decode stage for the 19-bit ISA with a one-entry ID/EX register.
// Optional macro ID_DECODE_PERF_EN adds accept and stall counters.
module id_decode_stage #(
    parameter int IW     = 19,
    parameter int DW     = 16,
    parameter int MC_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
`ifdef ID_DECODE_PERF_EN
    output logic [31:0] perf_instr_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    id_decode_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_MC_WAIT
    } state_t;

    localparam logic [3:0] MC_INIT = (MC_LAT > 1) ? 4'(MC_LAT - 2) : 4'd0;

    localparam int C_RD1  = 0;
    localparam int C_RD2  = 1;
    localparam int C_WR   = 2;
    localparam int C_SIN  = 3;
    localparam int C_SOUT = 4;
    localparam int C_RT   = 9;
    localparam int C_IT   = 10;
    localparam int C_BEQ  = 11;
    localparam int C_BNE  = 12;
    localparam int C_JT   = 13;
    localparam int C_PS   = 14;
    localparam int C_MW   = 15;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [15:0]   r_ctrl;
    logic [3:0]    r_func;
    logic [DW-1:0] r_imm;
    logic          r_illegal;

    logic [2:0]    w_op;
    logic [3:0]    w_func;
    logic [15:0]   w_ctrl;
    logic [13:0]   w_imm;
    logic          w_illegal;
    logic          w_mc;
    logic          w_in_ready;
    logic          w_accept;

    assign w_op   = bus.ir_in[IW-1:IW-3];
    assign w_func = bus.ir_in[3:0];

    always_comb begin
        w_ctrl    = '0;
        w_imm     = '0;
        w_illegal = 1'b0;
        w_mc      = 1'b0;
        case (w_op)
            3'b000: begin
                w_ctrl[C_RT]  = 1'b1;
                w_ctrl[C_WR]  = 1'b1;
                w_ctrl[C_RD1] = 1'b1;
                w_ctrl[C_RD2] = 1'b1;
                w_ctrl[6:5]   = 2'b01;
                w_ctrl[8:7]   = 2'b01;
                if (w_func == 4'd4 || w_func == 4'd5) begin
                    w_ctrl[C_RD2] = 1'b0;
                    w_ctrl[8:7]   = 2'b10;
                end else if (w_func == 4'd9) begin
                    w_ctrl[C_RD2] = 1'b0;
                    w_ctrl[8:7]   = 2'b00;
                end else if (w_func >= 4'd10 && w_func <= 4'd12) begin
                    // FFT/ENC/DEC run in the multi-cycle unit
                    w_ctrl[C_RD1] = 1'b0;
                    w_ctrl[6:5]   = 2'b00;
                    w_mc          = 1'b1;
                end
            end
            3'b001: begin
                w_ctrl[C_IT] = 1'b1;
                if (bus.ir_in[0]) begin
                    w_ctrl[C_RD1] = 1'b1;
                    w_ctrl[C_MW]  = 1'b1;
                    w_imm = {6'b0, bus.ir_in[15:12], bus.ir_in[7:4]};
                end else begin
                    w_ctrl[C_WR] = 1'b1;
                    w_imm = {6'b0, bus.ir_in[15:8]};
                end
            end
            3'b010, 3'b011: begin
                w_ctrl[C_BEQ] = (w_op == 3'b010);
                w_ctrl[C_BNE] = (w_op == 3'b011);
                w_ctrl[C_RD1] = 1'b1;
                w_ctrl[C_RD2] = 1'b1;
                w_ctrl[6:5]   = 2'b01;
                w_ctrl[8:7]   = 2'b01;
                w_imm = {6'b0, bus.ir_in[7:0]};
            end
            3'b100: begin
                w_ctrl[C_JT] = 1'b1;
                w_imm = bus.ir_in[15:2];
                if (bus.ir_in[1:0] == 2'b01) begin
                    w_ctrl[6:5]   = 2'b10;
                    w_ctrl[8:7]   = 2'b11;
                    w_ctrl[C_SIN] = 1'b1;
                end else if (bus.ir_in[1:0] == 2'b10) begin
                    w_ctrl[C_SOUT] = 1'b1;
                end
            end
            3'b101: begin
                w_ctrl[C_PS]  = 1'b1;
                w_ctrl[C_RD1] = 1'b1;
                w_ctrl[C_RD2] = 1'b1;
                w_ctrl[6:5]   = 2'b01;
                w_ctrl[8:7]   = 2'b01;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_in_ready = !rst && !flush &&
                        (r_state == S_EMPTY ||
                         (r_state == S_FULL && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_EMPTY;
            r_cnt     <= '0;
            r_ctrl    <= '0;
            r_func    <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_ctrl    <= w_ctrl;
            r_func    <= w_func;
            r_imm     <= DW'(w_imm);
            r_illegal <= w_illegal;
            if (w_mc && MC_LAT > 1) begin
                r_state <= S_MC_WAIT;
                r_cnt   <= MC_INIT;
            end else begin
                r_state <= S_FULL;
            end
        end else begin
            unique case (r_state)
                S_FULL: begin
                    if (bus.out_ready) r_state <= S_EMPTY;
                end
                S_MC_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_FULL;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == S_FULL);
    assign bus.ctrl_out    = r_ctrl;
    assign bus.func_out    = r_func;
    assign bus.imm_out     = r_imm;
    assign bus.illegal_out = r_illegal;

`ifdef ID_DECODE_PERF_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == S_FULL && !bus.out_ready) ||
                     (r_state == S_MC_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) r_perf_instr <= r_perf_instr + 32'd1;
            if (w_stall)  r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_instr_cnt = r_perf_instr;
    assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed scenarios plus a
// randomized run against a countdown-to-visibility reference model.
module tb_id_decode_stage;
    localparam int IW     = 19;
    localparam int DW     = 16;
    localparam int MC_LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    id_decode_stage_if #(.IW(IW), .DW(DW)) bus ();

`ifdef ID_DECODE_PERF_EN
    logic [31:0] perf_instr_cnt;
    logic [31:0] perf_stall_cnt;
    int          acc_cnt = 0;

    always @(posedge clk) begin
        if (rst) acc_cnt <= 0;
        else if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    end
`endif

    id_decode_stage #(.IW(IW), .DW(DW), .MC_LAT(MC_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
`ifdef ID_DECODE_PERF_EN
        .perf_instr_cnt (perf_instr_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .bus            (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_ctrl(input logic [18:0] ir);
        logic rd1, rd2, wr, sin, sout, rt, it, bq, bn, jt, pt, mw;
        logic [1:0] o1, o2;
        int f;
        {rd1, rd2, wr, sin, sout, rt, it, bq, bn, jt, pt, mw} = '0;
        o1 = 2'd0;
        o2 = 2'd0;
        f  = int'(ir[3:0]);
        case (int'(ir[18:16]))
            0: begin
                rt = 1; wr = 1; rd1 = 1; rd2 = 1; o1 = 1; o2 = 1;
                if (f == 4 || f == 5) begin rd2 = 0; o2 = 2; end
                else if (f == 9) begin rd2 = 0; o2 = 0; end
                else if (f >= 10 && f <= 12) begin rd1 = 0; o1 = 0; end
            end
            1: begin
                it = 1;
                if (ir[0]) begin rd1 = 1; mw = 1; end
                else wr = 1;
            end
            2: begin bq = 1; rd1 = 1; rd2 = 1; o1 = 1; o2 = 1; end
            3: begin bn = 1; rd1 = 1; rd2 = 1; o1 = 1; o2 = 1; end
            4: begin
                jt = 1;
                if (ir[1:0] == 2'b01) begin o1 = 2; o2 = 3; sin = 1; end
                else if (ir[1:0] == 2'b10) sout = 1;
            end
            5: begin pt = 1; rd1 = 1; rd2 = 1; o1 = 1; o2 = 1; end
            default: ;
        endcase
        return {mw, pt, jt, bn, bq, it, rt, o2, o1, sout, sin, wr, rd2, rd1};
    endfunction

    function automatic logic [15:0] ref_imm(input logic [18:0] ir);
        int v;
        int op;
        op = int'(ir[18:16]);
        v  = 0;
        if (op == 1) begin
            if (ir[0]) v = int'(ir[15:12]) * 16 + int'(ir[7:4]);
            else       v = int'(ir[15:8]);
        end else if (op == 2 || op == 3) begin
            v = int'(ir[7:0]);
        end else if (op == 4) begin
            v = (int'(ir) / 4) % 16384;
        end
        return 16'(v);
    endfunction

    function automatic bit ref_mc(input logic [18:0] ir);
        return ir[18:16] == 3'd0 && ir[3:0] >= 4'd10 && ir[3:0] <= 4'd12;
    endfunction

    task automatic test_reset();
        rst = 1; flush = 0;
        bus.in_valid = 1; bus.ir_in = 19'h0_0001; bus.out_ready = 1;
        cyc();
        cyc();
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
        end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.ctrl_out !== 16'h0 ||
            bus.imm_out !== 16'h0 || bus.func_out !== 4'h0 ||
            bus.illegal_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs got v=%b c=%h i=%h f=%h il=%b want all 0",
                     bus.out_valid, bus.ctrl_out, bus.imm_out,
                     bus.func_out, bus.illegal_out);
        end
        rst = 0; bus.in_valid = 0;
        cyc();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_accept got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_r_add();
        bus.in_valid = 1; bus.ir_in = 19'h0_0001; bus.out_ready = 1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_in_ready got %b want 1", bus.in_ready);
        end
        cyc();
        bus.in_valid = 0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.ctrl_out !== 16'h02A7 ||
            bus.imm_out !== 16'h0 || bus.func_out !== 4'h1) begin
            n_fail++;
            $display("FAIL add_decode got v=%b c=%h i=%h f=%h want 1 02a7 0000 1",
                     bus.out_valid, bus.ctrl_out, bus.imm_out, bus.func_out);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ready_full got %b want 1", bus.in_ready);
        end
        cyc();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_drain got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1; bus.ir_in = 19'h1_AB00; bus.out_ready = 1;
        cyc();
        bus.ir_in = 19'h1_C0D1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.imm_out !== 16'h00AB ||
            bus.ctrl_out[15] !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_load got v=%b i=%h mw=%b rdy=%b want 1 00ab 0 1",
                     bus.out_valid, bus.imm_out, bus.ctrl_out[15], bus.in_ready);
        end
        cyc();
        bus.in_valid = 0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.imm_out !== 16'h00CD ||
            bus.ctrl_out[15] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_store got v=%b i=%h mw=%b want 1 00cd 1",
                     bus.out_valid, bus.imm_out, bus.ctrl_out[15]);
        end
        cyc();
    endtask

    task automatic test_multicycle();
        bus.in_valid = 1; bus.ir_in = 19'h0_000A; bus.out_ready = 1;
        cyc();
        bus.ir_in = 19'h0_0001;
        for (int i = 1; i < MC_LAT; i++) begin
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL mc_wait cycle %0d got v=%b rdy=%b want 0 0",
                         i, bus.out_valid, bus.in_ready);
            end
            if (i == MC_LAT - 1) bus.in_valid = 0;
            cyc();
        end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.ctrl_out !== 16'h0286 ||
            bus.func_out !== 4'hA) begin
            n_fail++;
            $display("FAIL mc_emit got v=%b c=%h f=%h want 1 0286 a",
                     bus.out_valid, bus.ctrl_out, bus.func_out);
        end
        cyc();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_drain got out_valid=%b want 0 (blocked add leaked)",
                     bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1; bus.ir_in = 19'h4_0015; bus.out_ready = 1;
        cyc();
        bus.ir_in = 19'h0_0001; bus.out_ready = 0;
        repeat (5) begin
            #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.imm_out !== 16'h0005 ||
                bus.ctrl_out !== 16'h21C8 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold got v=%b i=%h c=%h rdy=%b want 1 0005 21c8 0",
                         bus.out_valid, bus.imm_out, bus.ctrl_out, bus.in_ready);
            end
            cyc();
        end
        bus.in_valid = 0; bus.out_ready = 1;
        cyc();
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.in_valid = 1; bus.ir_in = 19'h0_000B; bus.out_ready = 1;
        cyc();
        bus.in_valid = 0;
        cyc();
        flush = 1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_mc_ready got %b want 0", bus.in_ready);
        end
        cyc();
        flush = 0;
        for (int i = 0; i < MC_LAT + 2; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_mc_late cycle %0d got out_valid=%b want 0",
                         i, bus.out_valid);
            end
            cyc();
        end
        bus.in_valid = 1; bus.ir_in = 19'h1_AB00; bus.out_ready = 0;
        cyc();
        bus.ir_in = 19'h0_0001; bus.out_ready = 1; flush = 1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full got rdy=%b v=%b want 0 1",
                     bus.in_ready, bus.out_valid);
        end
        cyc();
        flush = 0; bus.in_valid = 0;
        repeat (3) begin
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_full_after got out_valid=%b want 0",
                         bus.out_valid);
            end
            cyc();
        end
    endtask

    task automatic test_illegal();
        bus.in_valid = 1; bus.ir_in = 19'h7_FFFF; bus.out_ready = 1;
        cyc();
        bus.in_valid = 0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.illegal_out !== 1'b1 ||
            bus.ctrl_out !== 16'h0 || bus.imm_out !== 16'h0) begin
            n_fail++;
            $display("FAIL illegal got v=%b il=%b c=%h i=%h want 1 1 0000 0000",
                     bus.out_valid, bus.illegal_out, bus.ctrl_out, bus.imm_out);
        end
        cyc();
    endtask

    task automatic test_random();
        bit          have;
        int          wait_n;
        logic [15:0] e_ctrl;
        logic [15:0] e_imm;
        logic [3:0]  e_func;
        logic        e_ill;
        logic        e_rdy;
        logic [18:0] ir;
        rst = 1; flush = 0; bus.in_valid = 0;
        cyc();
        rst = 0;
        have = 0; wait_n = 0;
        e_ctrl = '0; e_imm = '0; e_func = '0; e_ill = 0;
        for (int n = 0; n < 400; n++) begin
            ir = 19'($urandom);
            if ($urandom_range(0, 3) == 0) ir[18:16] = 3'd0;
            bus.ir_in     = ir;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
            #1;
            e_rdy = !flush && (!have || (wait_n == 0 && bus.out_ready));
            n_tests++;
            if (bus.in_ready !== e_rdy) begin
                n_fail++;
                $display("FAIL rnd_in_ready step %0d got %b want %b",
                         n, bus.in_ready, e_rdy);
            end
            if (flush) begin
                have = 0; wait_n = 0;
            end else if (bus.in_valid && e_rdy) begin
                have   = 1;
                wait_n = ref_mc(ir) ? MC_LAT - 1 : 0;
                e_ctrl = ref_ctrl(ir);
                e_imm  = ref_imm(ir);
                e_func = ir[3:0];
                e_ill  = (ir[18:17] == 2'b11);
            end else if (have && wait_n == 0 && bus.out_ready) begin
                have = 0;
            end else if (have && wait_n > 0) begin
                wait_n--;
            end
            cyc();
            n_tests++;
            if (bus.out_valid !== (have && wait_n == 0)) begin
                n_fail++;
                $display("FAIL rnd_out_valid step %0d got %b want %b",
                         n, bus.out_valid, (have && wait_n == 0));
            end
            if (have && wait_n == 0) begin
                n_tests++;
                if (bus.ctrl_out !== e_ctrl || bus.imm_out !== e_imm ||
                    bus.func_out !== e_func || bus.illegal_out !== e_ill) begin
                    n_fail++;
                    $display("FAIL rnd_payload step %0d got c=%h i=%h f=%h il=%b want c=%h i=%h f=%h il=%b",
                             n, bus.ctrl_out, bus.imm_out, bus.func_out,
                             bus.illegal_out, e_ctrl, e_imm, e_func, e_ill);
                end
            end
        end
        flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        cyc();
        cyc();
    endtask

`ifdef ID_DECODE_PERF_EN
    task automatic test_perf();
        n_tests++;
        if (perf_instr_cnt !== 32'(acc_cnt)) begin
            n_fail++;
            $display("FAIL perf_instr got %0d want %0d", perf_instr_cnt, acc_cnt);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; flush = 0;
        bus.in_valid = 0; bus.ir_in = '0; bus.out_ready = 0;
        test_reset();
        test_r_add();
        test_back_to_back();
        test_multicycle();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
`ifdef ID_DECODE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the 19-bit ISA.
- Accepts an instruction word, decodes opcode and func into the control bundle and zero-extended immediate, and holds the result in a one-entry ID/EX pipeline register.
- Stalls multi-cycle R-type ops (FFT/ENC/DEC) for a programmable latency.
- Supports backpressure and flush from the hazard unit.

Parameters:
- IW, 19, instruction width; must be >=19; opcode = ir_in[IW-1:IW-3], func = ir_in[3:0], other fields at the fixed low-bit positions below.
- DW, 16, immediate output width; must be >=14.
- MC_LAT, 4, total cycles from acceptance of func 10/11/12 R-type to out_valid; range 1..16.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  discard held/pending instruction
- in_valid  in  1  ir_in valid
- in_ready  out  1  stage can accept
- ir_in  in  IW  instruction word
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- ctrl_out  out  16  control bundle: [0] rd_en1, [1] rd_en2, [2] wr_en, [3] stack_in, [4] stack_out, [6:5] op1_sel, [8:7] op2_sel, [9] r_type, [10] i_type, [11] beq, [12] bne, [13] j_type, [14] ps_type, [15] mem_wr
- func_out  out  4  ir[3:0] of held instruction
- imm_out  out  DW  zero-extended immediate
- illegal_out  out  1  opcode 6 or 7

Behaviour:
- Reset: state EMPTY; out_valid, ctrl_out, func_out, imm_out, illegal_out and counter all 0; in_ready 0 while rst is high.
- States:
  - EMPTY: no entry.
  - FULL: out_valid=1.
  - MC_WAIT: entry captured, out_valid=0, counter running.
- in_ready = !rst && !flush && (state==EMPTY || (state==FULL && out_ready)). MC_WAIT always blocks.
- Accept = in_valid && in_ready. Decode is registered, so latency is 1 cycle: out_valid rises the cycle after accept.
- Exception: accepted R-type with func 10/11/12 and MC_LAT>1 enters MC_WAIT with counter=MC_LAT-2 and decrements each cycle. At counter==0 it moves to FULL, so out_valid rises exactly MC_LAT cycles after accept. MC_LAT=1 means no wait state.
- FULL && out_ready && !accept -> EMPTY. FULL && out_ready && accept -> reload; back-to-back throughput is 1/cycle.
- FULL && !out_ready: all outputs are held stable.
- Decode:
  - Op 000 R: r_type, wr_en, rd_en1/2, op1/op2=01, imm=0.
    - func 4/5: rd_en2=0, op2=10.
    - func 9: rd_en2=0, op2=00.
    - func 10/11/12: rd_en1=0, op1=00.
  - Op 001 I: op1/op2=00.
    - ir[0]=1 store: imm={ir[15:12],ir[7:4]}, rd_en1, mem_wr.
    - Else load: imm=ir[15:8], wr_en.
  - Op 010 beq / 011 bne: imm=ir[7:0], rd_en1/2, op1/op2=01.
  - Op 100 J: imm=ir[15:2], op1/op2=00.
    - ir[1:0]=01 CALL: op1=10, op2=11, stack_in.
    - ir[1:0]=10 RET: stack_out.
  - Op 101 PS: rd_en1/2, op1/op2=01, imm=0.
  - Op 110/111: ctrl=0, imm=0, illegal_out=1, still presented with out_valid.
- Every unset ctrl bit is 0; no latched values carry over between instructions.
- flush (synchronous): next state EMPTY, out_valid=0, counter cleared, ctrl/imm unchanged but invalid. Flush overrides simultaneous accept (in_ready=0) and aborts MC_WAIT.
- rst overrides flush.
- rst mid-MC_WAIT: EMPTY next cycle, nothing emitted.

Optional Feature:
- Macro ID_DECODE_PERF_EN.
- When defined, adds outputs perf_instr_cnt (32) and perf_stall_cnt (32).
  - perf_instr_cnt increments on each accept.
  - perf_stall_cnt increments each cycle that (state==FULL && !out_ready) || state==MC_WAIT.
  - Both wrap at 2^32, clear on rst, and are unaffected by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then in_valid=1, ir_in=19'h0_0001 (R ADD), out_ready=1 -> next cycle out_valid=1, ctrl_out=16'h02A7, imm_out=0; in_ready stays 1.
- Back-to-back LOAD 19'h1_AB00 then STORE 19'h1_C0D1 with out_ready=1 -> imm_out 16'h00AB then 16'h00CD; mem_wr 0 then 1; one result per cycle.
- R func 10 (19'h0_000A), MC_LAT=4 -> out_valid low for 3 cycles, high on 4th; in_ready=0 throughout MC_WAIT; ctrl_out op1_sel=00, rd_en1=0.
- CALL 19'h4_0015 with out_ready=0 for 5 cycles -> outputs stable: imm_out=16'h0005, stack_in=1, op1=10, op2=11; in_ready=0. After release -> EMPTY.
- flush asserted during MC_WAIT, and separately with in_valid=1 in FULL -> out_valid=0 next cycle, nothing accepted, no late emission.
- Opcode 7 (19'h7_FFFF) -> out_valid=1, illegal_out=1, ctrl_out=0, imm_out=0. With ID_DECODE_PERF_EN after all scenarios, perf_instr_cnt equals the number of accepts.
